// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Optional forwarding is selected by the HAZ_FORWARD_EN macro.
package pipeline_hazard_controller_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam int STALL_CNT_W = 16;
  localparam int MD_CNT_W    = 4;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_match_unit.sv
// Per-operand match and forwarding-source selection (hazard_match_unit).
// HAZ_FORWARD_EN selects real forwarding; otherwise the source is always the regfile.
module hazard_match_unit
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] operand,
  input  logic       operand_used,
  input  logic [4:0] ex_reg,
  input  logic       ex_rf_enable,
  input  logic       ex_load,
  input  logic [4:0] mem_reg,
  input  logic       mem_rf_enable,
  input  logic [4:0] wb_reg,
  input  logic       wb_rf_enable,
  output logic [1:0] fwd_sel,
  output logic       load_hit,
  output logic       any_hit
);

  logic ex_match;
  logic mem_match;
  logic wb_match;

  assign ex_match  = operand_used && ex_rf_enable  && (ex_reg  != 5'd0) && (ex_reg  == operand);
  assign mem_match = operand_used && mem_rf_enable && (mem_reg != 5'd0) && (mem_reg == operand);
  assign wb_match  = operand_used && wb_rf_enable  && (wb_reg  != 5'd0) && (wb_reg  == operand);

  assign load_hit = ex_match && ex_load;
  assign any_hit  = ex_match || mem_match || wb_match;

  always_comb begin
    fwd_sel = FWD_RF;
`ifdef HAZ_FORWARD_EN
    // A load result is not ready in EX, so fall through to older stages.
    if (ex_match && !ex_load) fwd_sel = FWD_EX;
    else if (mem_match)       fwd_sel = FWD_MEM;
    else if (wb_match)        fwd_sel = FWD_WB;
`endif
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/forwarding control with a HI/LO multiply-divide busy tracker.
// Build with HAZ_FORWARD_EN for forwarding; without it every RAW match stalls.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4
)
(
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [4:0]             ID_RS,
  input  logic [4:0]             ID_RT,
  input  logic                   ID_USES_RT,
  input  logic                   ID_MULDIV,
  input  logic                   ID_READS_HILO,
  input  logic                   ID_BRANCH_TAKEN,
  input  logic [4:0]             EX_REG,
  input  logic [4:0]             MEM_REG,
  input  logic [4:0]             WB_REG,
  input  logic                   EX_RF_ENABLE,
  input  logic                   MEM_RF_ENABLE,
  input  logic                   WB_RF_ENABLE,
  input  logic                   EX_LOAD_INSTR,
  output logic                   PC_LE,
  output logic                   IF_ID_LE,
  output logic                   IF_ID_FLUSH,
  output logic                   ID_EX_NOP,
  output logic [1:0]             FWD_A,
  output logic [1:0]             FWD_B,
  output logic                   MULDIV_BUSY,
  output logic [STALL_CNT_W-1:0] STALL_CNT
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_LAT - 1);

  hz_state_t              state_q, state_d;
  logic [MD_CNT_W-1:0]    md_cnt_q, md_cnt_d;
  logic                   busy_q, busy_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs_load_hit, rs_any_hit;
  logic rt_load_hit, rt_any_hit;
  logic hilo_hazard;
  logic stall;

  hazard_match_unit u_match_rs (
    .operand       (ID_RS),
    .operand_used  (1'b1),
    .ex_reg        (EX_REG),
    .ex_rf_enable  (EX_RF_ENABLE),
    .ex_load       (EX_LOAD_INSTR),
    .mem_reg       (MEM_REG),
    .mem_rf_enable (MEM_RF_ENABLE),
    .wb_reg        (WB_REG),
    .wb_rf_enable  (WB_RF_ENABLE),
    .fwd_sel       (FWD_A),
    .load_hit      (rs_load_hit),
    .any_hit       (rs_any_hit)
  );

  hazard_match_unit u_match_rt (
    .operand       (ID_RT),
    .operand_used  (ID_USES_RT),
    .ex_reg        (EX_REG),
    .ex_rf_enable  (EX_RF_ENABLE),
    .ex_load       (EX_LOAD_INSTR),
    .mem_reg       (MEM_REG),
    .mem_rf_enable (MEM_RF_ENABLE),
    .wb_reg        (WB_REG),
    .wb_rf_enable  (WB_RF_ENABLE),
    .fwd_sel       (FWD_B),
    .load_hit      (rt_load_hit),
    .any_hit       (rt_any_hit)
  );

  // The unit is treated as idle while reset is held, even before the flop clears.
  assign hilo_hazard = busy_q && !Reset && (ID_MULDIV || ID_READS_HILO);

  always_comb begin
    stall = rs_load_hit || rt_load_hit || hilo_hazard;
`ifndef HAZ_FORWARD_EN
    stall = stall || rs_any_hit || rt_any_hit;
`endif
  end

  assign PC_LE       = !stall;
  assign IF_ID_LE    = !stall;
  assign ID_EX_NOP   = stall;
  assign IF_ID_FLUSH = ID_BRANCH_TAKEN && !stall;
  assign MULDIV_BUSY = busy_q;
  assign STALL_CNT   = stall_cnt_q;

  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (ID_MULDIV && !stall) begin
          state_d  = ST_MD_BUSY;
          md_cnt_d = MD_LOAD;
        end
      end
      ST_MD_BUSY: begin
        if (md_cnt_q == '0) state_d = ST_RUN;
        else                md_cnt_d = md_cnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d == ST_MD_BUSY);
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      md_cnt_q    <= '0;
      busy_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller against a cycle-level reference model.
module tb_pipeline_hazard_controller;

  localparam int LAT = 4;
`ifdef HAZ_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  ID_RS, ID_RT, EX_REG, MEM_REG, WB_REG;
  logic        ID_USES_RT, ID_MULDIV, ID_READS_HILO, ID_BRANCH_TAKEN;
  logic        EX_RF_ENABLE, MEM_RF_ENABLE, WB_RF_ENABLE, EX_LOAD_INSTR;
  logic        PC_LE, IF_ID_LE, IF_ID_FLUSH, ID_EX_NOP, MULDIV_BUSY;
  logic [1:0]  FWD_A, FWD_B;
  logic [15:0] STALL_CNT;

  int checks = 0;
  int errors = 0;
  int m_busy_left = 0;
  int m_stall_cnt = 0;

  pipeline_hazard_controller #(.MULDIV_LAT(LAT)) dut (
    .Clk(Clk), .Reset(Reset),
    .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_USES_RT(ID_USES_RT),
    .ID_MULDIV(ID_MULDIV), .ID_READS_HILO(ID_READS_HILO), .ID_BRANCH_TAKEN(ID_BRANCH_TAKEN),
    .EX_REG(EX_REG), .MEM_REG(MEM_REG), .WB_REG(WB_REG),
    .EX_RF_ENABLE(EX_RF_ENABLE), .MEM_RF_ENABLE(MEM_RF_ENABLE), .WB_RF_ENABLE(WB_RF_ENABLE),
    .EX_LOAD_INSTR(EX_LOAD_INSTR),
    .PC_LE(PC_LE), .IF_ID_LE(IF_ID_LE), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_NOP(ID_EX_NOP),
    .FWD_A(FWD_A), .FWD_B(FWD_B), .MULDIV_BUSY(MULDIV_BUSY), .STALL_CNT(STALL_CNT)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  // Walk stages oldest to youngest so the youngest match wins.
  function automatic void ref_operand(input logic [4:0] op, input bit used,
                                      output logic [1:0] src, output bit load_hit, output bit any_hit);
    logic [4:0] regs [3];
    bit         en [3];
    regs = '{EX_REG, MEM_REG, WB_REG};
    en   = '{EX_RF_ENABLE, MEM_RF_ENABLE, WB_RF_ENABLE};
    src = 2'd0; load_hit = 1'b0; any_hit = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      if (used && en[i] && regs[i] != 5'd0 && regs[i] == op) begin
        any_hit = 1'b1;
        if (i == 0 && EX_LOAD_INSTR) load_hit = 1'b1;
        else src = 2'(i + 1);
      end
    end
    if (!FWD_ON) src = 2'd0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ID_RS = 5'd0; ID_RT = 5'd0; ID_USES_RT = 1'b0;
    ID_MULDIV = 1'b0; ID_READS_HILO = 1'b0; ID_BRANCH_TAKEN = 1'b0;
    EX_REG = 5'd0; MEM_REG = 5'd0; WB_REG = 5'd0;
    EX_RF_ENABLE = 1'b0; MEM_RF_ENABLE = 1'b0; WB_RF_ENABLE = 1'b0;
    EX_LOAD_INSTR = 1'b0;
  endtask

  // Compares all outputs mid-cycle, then advances one clock and the model with it.
  task automatic check_cycle(input string name);
    logic [1:0] ea, eb;
    bit la, lb, aa, ab, hilo, stall;
    #2;
    ref_operand(ID_RS, 1'b1, ea, la, aa);
    ref_operand(ID_RT, ID_USES_RT, eb, lb, ab);
    hilo  = (m_busy_left > 0) && !Reset && (ID_MULDIV || ID_READS_HILO);
    stall = la || lb || hilo || (!FWD_ON && (aa || ab));
    checks++;
    if (FWD_A !== ea) begin errors++; $display("FAIL %s fwd_a: got %0d want %0d", name, FWD_A, ea); end
    checks++;
    if (FWD_B !== eb) begin errors++; $display("FAIL %s fwd_b: got %0d want %0d", name, FWD_B, eb); end
    checks++;
    if (PC_LE !== !stall) begin errors++; $display("FAIL %s pc_le: got %b want %b", name, PC_LE, !stall); end
    checks++;
    if (IF_ID_LE !== !stall) begin errors++; $display("FAIL %s if_id_le: got %b want %b", name, IF_ID_LE, !stall); end
    checks++;
    if (ID_EX_NOP !== stall) begin errors++; $display("FAIL %s id_ex_nop: got %b want %b", name, ID_EX_NOP, stall); end
    checks++;
    if (IF_ID_FLUSH !== (ID_BRANCH_TAKEN && !stall)) begin
      errors++; $display("FAIL %s if_id_flush: got %b want %b", name, IF_ID_FLUSH, ID_BRANCH_TAKEN && !stall);
    end
    checks++;
    if (MULDIV_BUSY !== (m_busy_left > 0)) begin
      errors++; $display("FAIL %s muldiv_busy: got %b want %b", name, MULDIV_BUSY, m_busy_left > 0);
    end
    checks++;
    if (STALL_CNT !== 16'(m_stall_cnt)) begin
      errors++; $display("FAIL %s stall_cnt: got %0d want %0d", name, STALL_CNT, m_stall_cnt);
    end
    @(posedge Clk);
    if (Reset) begin
      m_busy_left = 0; m_stall_cnt = 0;
    end else begin
      if (stall && m_stall_cnt < 65535) m_stall_cnt++;
      if (m_busy_left > 0) m_busy_left--;
      else if (ID_MULDIV && !stall) m_busy_left = LAT;
    end
    #1;
  endtask

  task automatic drain_busy();
    idle_inputs();
    for (int i = 0; i < 20 && m_busy_left > 0; i++) check_cycle("drain");
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    Reset = 1'b1;
    @(posedge Clk); #1;
    m_busy_left = 0; m_stall_cnt = 0;
    check_cycle("reset_hold");
    Reset = 1'b0;
    check_cycle("reset_release");
  endtask

  task automatic test_forwarding();
    idle_inputs();
    EX_REG = 5'd5; EX_RF_ENABLE = 1'b1; ID_RS = 5'd5;
    check_cycle("fwd_ex");
    MEM_REG = 5'd5; MEM_RF_ENABLE = 1'b1;
    #2;
    checks++;
    if (FWD_ON && FWD_A !== 2'b01) begin errors++; $display("FAIL fwd_ex_over_mem: got %b want 01", FWD_A); end
    else if (!FWD_ON && FWD_A !== 2'b00) begin errors++; $display("FAIL fwd_ex_over_mem: got %b want 00", FWD_A); end
    check_cycle("fwd_ex_mem");
    idle_inputs();
    WB_REG = 5'd9; WB_RF_ENABLE = 1'b1; ID_RT = 5'd9; ID_USES_RT = 1'b1;
    check_cycle("fwd_wb_rt");
    ID_USES_RT = 1'b0;
    check_cycle("fwd_rt_unused");
  endtask

  task automatic test_load_use();
    int cnt0;
    idle_inputs();
    cnt0 = m_stall_cnt;
    EX_REG = 5'd8; EX_RF_ENABLE = 1'b1; EX_LOAD_INSTR = 1'b1; ID_RT = 5'd8; ID_USES_RT = 1'b1;
    check_cycle("load_use");
    checks++;
    if (STALL_CNT !== 16'(cnt0 + 1)) begin errors++; $display("FAIL load_use_cnt: got %0d want %0d", STALL_CNT, cnt0 + 1); end
    EX_REG = 5'd0; EX_RF_ENABLE = 1'b0; EX_LOAD_INSTR = 1'b0;
    MEM_REG = 5'd8; MEM_RF_ENABLE = 1'b1;
    check_cycle("load_use_mem_fwd");
  endtask

  task automatic test_r0();
    idle_inputs();
    EX_REG = 5'd0; EX_RF_ENABLE = 1'b1; EX_LOAD_INSTR = 1'b1; ID_RS = 5'd0;
    #2;
    checks++;
    if (PC_LE !== 1'b1 || FWD_A !== 2'b00) begin
      errors++; $display("FAIL r0: got pc_le=%b fwd_a=%b want 1 00", PC_LE, FWD_A);
    end
    check_cycle("r0");
  endtask

  task automatic test_muldiv();
    int stalls;
    drain_busy();
    idle_inputs();
    ID_MULDIV = 1'b1;
    check_cycle("md_issue");
    ID_MULDIV = 1'b0; ID_READS_HILO = 1'b1;
    stalls = 0;
    for (int c = 1; c <= 5; c++) begin
      #2;
      if (!PC_LE) stalls++;
      check_cycle("md_mflo");
    end
    checks++;
    if (stalls != LAT) begin errors++; $display("FAIL md_mflo_stalls: got %0d want %0d", stalls, LAT); end
    drain_busy();
    ID_MULDIV = 1'b1;
    check_cycle("md_issue2");
    ID_MULDIV = 1'b0;
    check_cycle("md_gap");
    ID_MULDIV = 1'b1;
    for (int c = 2; c <= 5; c++) check_cycle("md_back_to_back");
    idle_inputs();
    checks++;
    if (MULDIV_BUSY !== 1'b1) begin errors++; $display("FAIL md_second_busy: got %b want 1", MULDIV_BUSY); end
    drain_busy();
  endtask

  task automatic test_branch();
    idle_inputs();
    ID_BRANCH_TAKEN = 1'b1;
    EX_REG = 5'd3; EX_RF_ENABLE = 1'b1; EX_LOAD_INSTR = 1'b1; ID_RS = 5'd3;
    check_cycle("branch_stalled");
    EX_REG = 5'd0; EX_RF_ENABLE = 1'b0; EX_LOAD_INSTR = 1'b0;
    #2;
    checks++;
    if (IF_ID_FLUSH !== 1'b1) begin errors++; $display("FAIL branch_flush: got %b want 1", IF_ID_FLUSH); end
    check_cycle("branch_flush");
  endtask

  task automatic test_reset_mid_busy();
    drain_busy();
    ID_MULDIV = 1'b1;
    check_cycle("rst_md_issue");
    ID_MULDIV = 1'b0;
    check_cycle("rst_md_cnt3");
    Reset = 1'b1;
    ID_READS_HILO = 1'b1;
    check_cycle("rst_md_cnt2");
    Reset = 1'b0;
    #2;
    checks++;
    if (MULDIV_BUSY !== 1'b0 || STALL_CNT !== 16'd0) begin
      errors++; $display("FAIL rst_mid_busy: got busy=%b cnt=%0d want 0 0", MULDIV_BUSY, STALL_CNT);
    end
    check_cycle("rst_after");
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      ID_RS = 5'($urandom_range(0, 3)); ID_RT = 5'($urandom_range(0, 3));
      EX_REG = 5'($urandom_range(0, 3)); MEM_REG = 5'($urandom_range(0, 3)); WB_REG = 5'($urandom_range(0, 3));
      ID_USES_RT = 1'($urandom_range(0, 1));
      EX_RF_ENABLE = 1'($urandom_range(0, 1)); MEM_RF_ENABLE = 1'($urandom_range(0, 1));
      WB_RF_ENABLE = 1'($urandom_range(0, 1)); EX_LOAD_INSTR = 1'($urandom_range(0, 1));
      ID_MULDIV = ($urandom_range(0, 5) == 0); ID_READS_HILO = ($urandom_range(0, 3) == 0);
      ID_BRANCH_TAKEN = 1'($urandom_range(0, 1));
      Reset = ($urandom_range(0, 60) == 0);
      check_cycle("random");
    end
    Reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    Reset = 1'b1; idle_inputs();
    check_cycle("sat_reset");
    Reset = 1'b0;
    EX_REG = 5'd8; EX_RF_ENABLE = 1'b1; EX_LOAD_INSTR = 1'b1; ID_RS = 5'd8;
    repeat (65540) @(posedge Clk);
    #1;
    m_stall_cnt = 65535;
    checks++;
    if (STALL_CNT !== 16'hFFFF) begin errors++; $display("FAIL stall_saturate: got %h want ffff", STALL_CNT); end
    check_cycle("sat_hold");
    idle_inputs();
    check_cycle("sat_idle");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Reset = 1'b1;
    idle_inputs();
    @(posedge Clk); #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_r0();
    test_muldiv();
    test_branch();
    test_reset_mid_busy();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
